// File: rtl/delay_line_pkg.sv
// Shared types and defaults for the delay line controller.
//   state_e          : controller state encoding
//   DELAY_CTR_WIDTH  : timestamp/delay width derived from the default delay
//   *_DEF            : default parameter values used by delay_line_ctrl
package delay_line_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH,
    LOAD
  } state_e;

  localparam int unsigned DEFAULT_DELAY_CYCLES = 92498;
  localparam int unsigned DELAY_CTR_WIDTH      = $clog2(DEFAULT_DELAY_CYCLES);
  localparam int unsigned MIN_DELAY_DEF        = 4;
  localparam int unsigned DRAIN_TIMEOUT_DEF    = 131072;
  localparam int unsigned DROP_WIDTH_DEF       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag.
//   clk, n_reset : clock, synchronous active-low reset
//   inc          : increment request (ignored once at all-ones)
//   count        : current count
//   saturated    : set when count reaches all-ones, held until reset
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             saturated
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
    sat_d = sat_q | (count_d == '1);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count     = count_q;
  assign saturated = sat_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// Run-time controller for the delay line datapath. Gates edge-detector
// writes into the timestamp FIFO, owns the active delay, sequences safe
// delay reconfiguration (drain/flush, wait for pulse idle, load, resume)
// and counts edges dropped on FIFO full.
//   clk, n_reset          : clock, synchronous active-low reset
//   enable                : 1 requests RUN, 0 requests IDLE
//   cfg_valid/cfg_ready   : host delay handshake; cfg_delay, cfg_flush payload
//   edge_in               : write request from the edge detector
//   fifo_full/fifo_empty  : FIFO status
//   pulse_active          : pulse generator busy
//   fifo_wr_en            : gated FIFO write (combinational)
//   fifo_clear            : one-cycle FIFO flush strobe
//   delay                 : active delay to the counter adder
//   running               : state is RUN
//   drop_count, drop_sat  : saturating count of edges lost to FIFO full
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned CTR_WIDTH     = DELAY_CTR_WIDTH,
  parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_CYCLES,
  parameter int unsigned MIN_DELAY     = MIN_DELAY_DEF,
  parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int unsigned DROP_WIDTH    = DROP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTR_WIDTH-1:0]  cfg_delay,
  input  logic                  cfg_flush,
  input  logic                  edge_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  pulse_active,
  output logic                  fifo_wr_en,
  output logic                  fifo_clear,
  output logic [CTR_WIDTH-1:0]  delay,
  output logic                  running,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  drop_sat
);

  localparam int unsigned TMO_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CTR_WIDTH-1:0] MIN_D     = CTR_WIDTH'(MIN_DELAY);
  localparam logic [CTR_WIDTH-1:0] DEFAULT_D = CTR_WIDTH'(DEFAULT_DELAY);

  state_e               state_q, state_d;
  logic [CTR_WIDTH-1:0] delay_q, delay_d;
  logic [CTR_WIDTH-1:0] pend_delay_q, pend_delay_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 running_q, running_d;
  logic                 fifo_clear_q, fifo_clear_d;
  logic                 xfer;
  logic                 in_run;

  function automatic logic [CTR_WIDTH-1:0] clamp_delay(input logic [CTR_WIDTH-1:0] d);
    return (d < MIN_D) ? MIN_D : d;
  endfunction

  assign xfer   = cfg_valid & cfg_ready_q;
  assign in_run = (state_q == RUN);

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    pend_delay_d = pend_delay_q;
    pend_valid_d = pend_valid_q;
    tmo_d        = '0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          delay_d = clamp_delay(cfg_delay);
        end
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          pend_delay_d = cfg_delay;
          pend_valid_d = 1'b1;
          state_d      = cfg_flush ? FLUSH : DRAIN;
        end else if (!enable) begin
          pend_valid_d = 1'b0;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        // A clean drain wins over the timeout on the same cycle.
        if (fifo_empty && !pulse_active) begin
          state_d = pend_valid_q ? LOAD : IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FLUSH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FLUSH: begin
        if (!pulse_active) begin
          state_d = pend_valid_q ? LOAD : IDLE;
        end
      end
      LOAD: begin
        delay_d      = clamp_delay(pend_delay_q);
        pend_valid_d = 1'b0;
        state_d      = enable ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs follow the next state so they align with state_q.
    cfg_ready_d  = (state_d == IDLE) || (state_d == RUN);
    running_d    = (state_d == RUN);
    fifo_clear_d = (state_d == FLUSH) && (state_q != FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      delay_q      <= DEFAULT_D;
      pend_delay_q <= '0;
      pend_valid_q <= 1'b0;
      tmo_q        <= '0;
      cfg_ready_q  <= 1'b0;
      running_q    <= 1'b0;
      fifo_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      pend_delay_q <= pend_delay_d;
      pend_valid_q <= pend_valid_d;
      tmo_q        <= tmo_d;
      cfg_ready_q  <= cfg_ready_d;
      running_q    <= running_d;
      fifo_clear_q <= fifo_clear_d;
    end
  end

  sat_counter #(
    .WIDTH(DROP_WIDTH)
  ) u_drop_cnt (
    .clk      (clk),
    .n_reset  (n_reset),
    .inc      (in_run & edge_in & fifo_full),
    .count    (drop_count),
    .saturated(drop_sat)
  );

  assign fifo_wr_en = in_run & edge_in & ~fifo_full;
  assign cfg_ready  = cfg_ready_q;
  assign running    = running_q;
  assign fifo_clear = fifo_clear_q;
  assign delay      = delay_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl (drain timeout shortened).
module tb_delay_line_ctrl;

  localparam int unsigned CW  = 17;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_delay;
  logic          cfg_flush;
  logic          edge_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pulse_active;
  logic          fifo_wr_en;
  logic          fifo_clear;
  logic [CW-1:0] delay;
  logic          running;
  logic [DW-1:0] drop_count;
  logic          drop_sat;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(
    .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_delay   (cfg_delay),
    .cfg_flush   (cfg_flush),
    .edge_in     (edge_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .pulse_active(pulse_active),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_clear  (fifo_clear),
    .delay       (delay),
    .running     (running),
    .drop_count  (drop_count),
    .drop_sat    (drop_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned wr_seen;
  int unsigned clr_seen;
  int unsigned n_edges;
  bit          found;

  initial begin
    n_reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_delay = '0;
    cfg_flush = 1'b0; edge_in = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    pulse_active = 1'b0;
    tick(); tick();
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_running", 32'(running), 0);
    check("rst_delay", 32'(delay), 92498);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_drop_sat", 32'(drop_sat), 0);
    check("rst_clear", 32'(fifo_clear), 0);

    n_reset = 1'b1;
    tick();
    check("idle_cfg_ready", 32'(cfg_ready), 1);
    check("idle_running", 32'(running), 0);

    // Enable, then three edges with FIFO not full.
    enable = 1'b1;
    tick();
    check("run_running", 32'(running), 1);
    wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      edge_in = 1'b1; #1;
      if (fifo_wr_en) wr_seen++;
      tick();
      edge_in = 1'b0; #1;
      if (fifo_wr_en) wr_seen++;
      tick();
    end
    check("run_writes", wr_seen, 3);
    check("run_drop0", 32'(drop_count), 0);
    check("run_delay", 32'(delay), 92498);

    // FIFO full: 70000 edges all dropped, counter saturates.
    fifo_full = 1'b1; edge_in = 1'b1; wr_seen = 0;
    for (int i = 0; i < 70000; i++) begin
      #1;
      if (fifo_wr_en) wr_seen++;
      tick();
    end
    edge_in = 1'b0; fifo_full = 1'b0;
    tick();
    check("full_no_writes", wr_seen, 0);
    check("full_drop_count", 32'(drop_count), 65535);
    check("full_drop_sat", 32'(drop_sat), 1);

    // Reconfigure to 1000 by draining; FIFO not empty for 50 cycles.
    cfg_valid = 1'b1; cfg_delay = 17'd1000; cfg_flush = 1'b0;
    fifo_empty = 1'b0; edge_in = 1'b1; #1;
    check("xfer_edge_written", 32'(fifo_wr_en), 1);
    tick();
    cfg_valid = 1'b0;
    check("drain_cfg_ready", 32'(cfg_ready), 0);
    check("drain_running", 32'(running), 0);
    wr_seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (fifo_wr_en) wr_seen++;
      tick();
    end
    check("drain_no_writes", wr_seen, 0);
    check("drain_delay_hold", 32'(delay), 92498);
    fifo_empty = 1'b1; edge_in = 1'b0;
    tick();
    check("load_delay_old", 32'(delay), 92498);
    tick();
    check("drain_new_delay", 32'(delay), 1000);
    check("drain_rerun", 32'(running), 1);
    check("drain_ready_back", 32'(cfg_ready), 1);

    // Reconfigure to 2 by flushing, pulse generator busy for a while.
    cfg_valid = 1'b1; cfg_delay = 17'd2; cfg_flush = 1'b1; pulse_active = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_flush = 1'b0;
    clr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (fifo_clear) clr_seen++;
      if (i == 3) pulse_active = 1'b0;
      tick();
    end
    check("flush_clear_once", clr_seen, 1);
    check("flush_delay_clamped", 32'(delay), 4);
    check("flush_rerun", 32'(running), 1);

    // Disable with FIFO stuck non-empty: timeout forces FLUSH.
    enable = 1'b0; fifo_empty = 1'b0;
    n_edges = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      n_edges++;
      if (fifo_clear) found = 1'b1;
    end
    check("tmo_seen", 32'(found), 1);
    check("tmo_cycles", n_edges, TMO + 1);
    clr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fifo_clear) clr_seen++;
    end
    check("tmo_clear_once", clr_seen, 0);
    check("tmo_idle_ready", 32'(cfg_ready), 1);
    check("tmo_idle_running", 32'(running), 0);
    check("tmo_delay_hold", 32'(delay), 4);

    // Reset during DRAIN with 500 pending.
    enable = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_delay = 17'd500;
    tick();
    cfg_valid = 1'b0;
    tick(); tick();
    n_reset = 1'b0; enable = 1'b0;
    tick();
    check("mid_rst_ready", 32'(cfg_ready), 0);
    check("mid_rst_delay", 32'(delay), 92498);
    check("mid_rst_drop", 32'(drop_count), 0);
    check("mid_rst_sat", 32'(drop_sat), 0);
    tick();
    n_reset = 1'b1; fifo_empty = 1'b1;
    tick();
    check("post_rst_ready", 32'(cfg_ready), 1);
    check("post_rst_running", 32'(running), 0);
    tick(); tick();
    check("post_rst_delay", 32'(delay), 92498);

    // IDLE load: clamp, then load together with enable.
    cfg_valid = 1'b1; cfg_delay = 17'd3;
    tick();
    check("idle_load_clamp", 32'(delay), 4);
    check("idle_load_stay", 32'(running), 0);
    cfg_delay = 17'd777; enable = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("idle_load_run_delay", 32'(delay), 777);
    check("idle_load_run", 32'(running), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Run-time controller for the delay line datapath. It gates edge-detector writes into the timestamp FIFO and owns the active delay value added to the free-running counter. It sequences safe delay reconfiguration: drain or flush the FIFO, wait for the pulse generator to go idle, load, resume. It also counts edges dropped on FIFO full. It sits between the edge detector, the FIFO and the counter adder, and is driven by a host-side config handshake.

## Interface
- CTR_WIDTH, 17, width of timestamp counter and delay value
- DEFAULT_DELAY, 92498, delay loaded at reset, in clk cycles after pipeline compensation
- MIN_DELAY, 4, smallest legal delay; lower requests are clamped up
- DRAIN_TIMEOUT, 131072, DRAIN cycles before forcing FLUSH
- DROP_WIDTH, 16, width of the drop counter
- clk  in  1  system clock
- n_reset  in  1  reset, synchronous, active-low
- enable  in  1  level; 1 requests RUN, 0 requests IDLE
- cfg_valid  in  1  new delay offered
- cfg_ready  out  1  controller can accept a delay
- cfg_delay  in  CTR_WIDTH  requested delay
- cfg_flush  in  1  sampled with cfg_delay; 1 discards queued pulses instead of draining
- edge_in  in  1  single-cycle write request from the edge detector
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- pulse_active  in  1  pulse generator busy
- fifo_wr_en  out  1  gated FIFO write enable
- fifo_clear  out  1  single-cycle FIFO flush strobe
- delay  out  CTR_WIDTH  active delay, fed to the counter adder
- running  out  1  state == RUN
- drop_count  out  DROP_WIDTH  edges lost to FIFO full, saturating
- drop_sat  out  1  drop_count has saturated

## Operation
- States: IDLE, RUN, DRAIN, FLUSH, LOAD.
- Reset values:
  - state IDLE; delay = DEFAULT_DELAY; pending = 0
  - cfg_ready 0; fifo_clear 0; running 0; drop_count 0; drop_sat 0
  - Reset does not assert fifo_clear.
- cfg_ready = 1 in IDLE and RUN only. A transfer happens when cfg_valid & cfg_ready.
- IDLE:
  - A transfer loads delay directly (clamped) and the state stays IDLE.
  - enable = 1 goes to RUN. If a transfer and enable occur together, the load and the move to RUN happen in the same cycle.
- RUN:
  - fifo_wr_en = edge_in & ~fifo_full.
  - edge_in & fifo_full increments drop_count, saturating at all-ones; drop_sat sets and stays set until reset.
  - A transfer latches {cfg_delay, cfg_flush} into pending, then goes to FLUSH if cfg_flush = 1, else DRAIN.
  - enable = 0 with no transfer goes to DRAIN with no pending load.
  - A transfer and enable = 0 together accept the cfg, go to DRAIN/FLUSH, and end in IDLE.
- DRAIN:
  - fifo_wr_en = 0; edges are ignored and not counted.
  - Leave when fifo_empty & ~pulse_active: go to LOAD if a load is pending, else IDLE.
  - After DRAIN_TIMEOUT cycles in DRAIN, go to FLUSH.
- FLUSH:
  - fifo_clear = 1 on the first FLUSH cycle only.
  - Then wait for ~pulse_active, and go to LOAD if pending, else IDLE.
- LOAD (one cycle):
  - delay <= max(pending, MIN_DELAY).
  - Next state is RUN if enable = 1, else IDLE.
- delay changes only in IDLE or LOAD, so it never changes while timestamps are queued.
- Clamp arithmetic is unsigned CTR_WIDTH; no wrap-around handling beyond the counter's natural modulo.

## Timing
- fifo_wr_en is combinational from edge_in, fifo_full and the registered state: zero added latency, so the datapath delay budget is unchanged.
- All other outputs are registered.
- cfg_ready drops the cycle after a RUN transfer.
- Transfer-to-new-delay latency:
  - IDLE: 1 cycle.
  - RUN with empty FIFO and idle pulse generator: 3 cycles (DRAIN, LOAD, then delay valid).
- The edge in the same cycle as a RUN transfer is still written; the first gated edge is the next cycle.
- Reset mid-sequence aborts immediately. The pending load is discarded and delay returns to DEFAULT_DELAY.

## Structure
- Package delay_line_pkg:
  - state enum
  - MIN_DELAY default
  - shared CTR_WIDTH derivation ($clog2 of the delay cycles)
- One sub-module: sat_counter (width parameter, inc input, count and saturated outputs), used for drop_count.
- DRAIN timeout counter is inline.

## Test plan
- Reset, then enable = 1, then 3 edges with FIFO not full → fifo_wr_en pulses 3×, drop_count = 0, delay = 92498.
- RUN, fifo_full = 1, 70000 edges → fifo_wr_en never high, drop_count = 65535, drop_sat = 1.
- RUN, cfg_delay = 1000 (cfg_flush = 0), fifo_empty = 0 for 50 cycles then 1, pulse_active = 0 → no writes during DRAIN, delay = 1000 one cycle after LOAD, running returns to 1.
- RUN, cfg_delay = 2 (cfg_flush = 1) → fifo_clear high exactly 1 cycle, delay = 4.
- DRAIN with fifo_empty held 0 → FLUSH entered after DRAIN_TIMEOUT cycles, fifo_clear pulses once.
- Reset asserted during DRAIN with pending 500 → IDLE, delay = 92498, cfg_ready = 0 during reset and 1 after.
